// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file: default geometry, a zero word,
// and the location of the program-counter entry.
package regfile_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_DEPTH   = 16;
   localparam int DEF_PC_STEP = 4;

   localparam logic [DEF_WIDTH-1:0] ZERO_WORD = '0;

   // The PC always occupies the highest index, whatever the depth.
   function automatic int pc_index(input int depth);
      return depth - 1;
   endfunction

   // Address width for a given depth; a one-entry file would still need one address bit.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage : regfile_pkg

// File: rtl/register_file_if.sv
// Bus bundle between decode/writeback/fetch (master) and the register file (slave).
import regfile_pkg::*;

interface register_file_if #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int AW = addr_width(DEPTH);

   logic             wr_en_n;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW-1:0]    rd_addr_a;
   logic [WIDTH-1:0] rd_data_a;
   logic [AW-1:0]    rd_addr_b;
   logic [WIDTH-1:0] rd_data_b;
   logic             pc_inc_n;
   logic [WIDTH-1:0] pc_out;

   modport master (
      output wr_en_n, wr_addr, wr_data, rd_addr_a, rd_addr_b, pc_inc_n,
      input  rd_data_a, rd_data_b, pc_out
   );

   modport slave (
      input  wr_en_n, wr_addr, wr_data, rd_addr_a, rd_addr_b, pc_inc_n,
      output rd_data_a, rd_data_b, pc_out
   );

endinterface : register_file_if

// File: rtl/regfile_cell.sv
// One register-file word: async active-low clear, active-low load enable.
import regfile_pkg::*;

module regfile_cell #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ld_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: every word carries its own async clear because the whole file must read 0
   // during reset; this stops the array mapping onto reset-less RAM macros.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q <= '0;
      end else if (!ld_n) begin
         // NOTE: non-blocking so all cells sample their D inputs from the same pre-edge state.
         q <= d;
      end
   end

endmodule : regfile_cell

// File: rtl/register_file.sv
// Multi-port register file with auto-incrementing PC at index DEPTH-1.
// Optional same-cycle write-through on the read ports: define REGFILE_WR_BYPASS_EN.
import regfile_pkg::*;

module register_file #(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int PC_STEP = DEF_PC_STEP
) (
   input  logic            clk,
   input  logic            clr,
   register_file_if.slave  bus
);

   localparam int AW     = addr_width(DEPTH);
   localparam int PC_IDX = pc_index(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_in_range;
   logic             wr_active;
   logic             pc_wr;
   logic             pc_ld_n;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   // Extra bit so the compare still works when DEPTH is exactly 2**AW.
   assign wr_in_range = ({1'b0, bus.wr_addr} < (AW+1)'(DEPTH));
   assign wr_active   = !bus.wr_en_n && wr_in_range;

   for (genvar i = 0; i < DEPTH - 1; i++) begin : g_gpr
      logic ld_n;
      assign ld_n = !(wr_active && (bus.wr_addr == AW'(i)));

      regfile_cell #(.WIDTH(WIDTH)) u_cell (
         .clk  (clk),
         .clr  (clr),
         .ld_n (ld_n),
         .d    (bus.wr_data),
         .q    (regs[i])
      );
   end

   // A write to the PC takes priority over the increment on the same edge.
   assign pc_wr   = wr_active && (bus.wr_addr == AW'(PC_IDX));
   assign pc_ld_n = !(pc_wr || !bus.pc_inc_n);
   assign pc_d    = pc_wr ? bus.wr_data : regs[PC_IDX] + WIDTH'(PC_STEP);

   regfile_cell #(.WIDTH(WIDTH)) u_pc (
      .clk  (clk),
      .clr  (clr),
      .ld_n (pc_ld_n),
      .d    (pc_d),
      .q    (regs[PC_IDX])
   );

   // Out-of-range addresses match no entry and fall through to zero.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      rd_a = WIDTH'(ZERO_WORD);
      rd_b = WIDTH'(ZERO_WORD);
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.rd_addr_a == AW'(i)) rd_a = regs[i];
         if (bus.rd_addr_b == AW'(i)) rd_b = regs[i];
      end
`ifdef REGFILE_WR_BYPASS_EN
      // Write-through only; a pending increment is never forwarded.
      if (wr_active && (bus.rd_addr_a == bus.wr_addr)) rd_a = bus.wr_data;
      if (wr_active && (bus.rd_addr_b == bus.wr_addr)) rd_b = bus.wr_data;
`else
`endif
   end

   assign bus.rd_data_a = rd_a;
   assign bus.rd_data_b = rd_b;
   assign bus.pc_out    = regs[PC_IDX];

endmodule : register_file
